// File: rtl/upd7800_clkgen.sv
// -----------------------------------------------------------------------------
// upd7800_clkgen
//
// Clock-phase and reset sequencer for the upd7800 CPU core. It divides CLK into
// the core's four-step machine cycle, issuing one-CLK-wide enables for the
// CP1/CP2 rising and falling edges, and holds the core's active-low reset for
// RES_CYCLES machine cycles after any reset source lets go.
//
// Parameters
//   DIV         CLK cycles per phase step (1..255); machine cycle = 4*DIV CLK
//   RES_CYCLES  machine cycles RESETB stays low after release (1..255)
//
// Ports
//   CLK          in   system clock, rising edge
//   RES          in   synchronous active-high reset of the whole block
//   CE           in   run enable; 0 freezes the sequencer (pause / savestate)
//   SOFT_RES     in   CPU-only reset request; phases keep running
//   CP1_POSEDGE  out  step-0 enable pulse
//   CP1_NEGEDGE  out  step-1 enable pulse
//   CP2_POSEDGE  out  step-2 enable pulse
//   CP2_NEGEDGE  out  step-3 enable pulse
//   CP1, CP2     out  clock levels, set/cleared together with their pulses
//   PHASE        out  current step number 0..3
//   RESETB       out  active-low reset to the CPU core
// -----------------------------------------------------------------------------
// state         | meaning
// STEP_CP1_RISE | next issued pulse is CP1_POSEDGE
// STEP_CP1_FALL | next issued pulse is CP1_NEGEDGE
// STEP_CP2_RISE | next issued pulse is CP2_POSEDGE
// STEP_CP2_FALL | next issued pulse is CP2_NEGEDGE
// -----------------------------------------------------------------------------
module upd7800_clkgen #(
  parameter int unsigned DIV        = 1,
  parameter int unsigned RES_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       CE,
  input  logic       SOFT_RES,
  output logic       CP1_POSEDGE,
  output logic       CP1_NEGEDGE,
  output logic       CP2_POSEDGE,
  output logic       CP2_NEGEDGE,
  output logic       CP1,
  output logic       CP2,
  output logic [1:0] PHASE,
  output logic       RESETB
);

  localparam int unsigned PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned RCNT_W = $clog2(RES_CYCLES + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(RES_CYCLES);

  typedef enum logic [1:0] {
    STEP_CP1_RISE = 2'd0,
    STEP_CP1_FALL = 2'd1,
    STEP_CP2_RISE = 2'd2,
    STEP_CP2_FALL = 2'd3
  } step_e;

  // Pulse vector bit index equals the step that produced it.
  localparam int unsigned P_CP1R = 0;
  localparam int unsigned P_CP1F = 1;
  localparam int unsigned P_CP2R = 2;
  localparam int unsigned P_CP2F = 3;

  logic [PRE_W-1:0]  pre_q,   pre_d;
  step_e             step_q,  step_d;
  logic [3:0]        pulse_q, pulse_d;
  logic              cp1_q,   cp1_d;
  logic              cp2_q,   cp2_d;
  logic [RCNT_W-1:0] rcnt_q,  rcnt_d;

  function automatic step_e step_next(input step_e s);
    step_e n;
    case (s)
      STEP_CP1_RISE: n = STEP_CP1_FALL;
      STEP_CP1_FALL: n = STEP_CP2_RISE;
      STEP_CP2_RISE: n = STEP_CP2_FALL;
      default:       n = STEP_CP1_RISE;
    endcase
    return n;
  endfunction

  always_comb begin
    pre_d   = pre_q;
    step_d  = step_q;
    pulse_d = '0;
    cp1_d   = cp1_q;
    cp2_d   = cp2_q;
    rcnt_d  = rcnt_q;

    if (CE) begin
      // A pulse is issued only at the start of each step's prescaler window.
      if (pre_q == '0) begin
        case (step_q)
          STEP_CP1_RISE: begin
            pulse_d[P_CP1R] = 1'b1;
            cp1_d           = 1'b1;
          end
          STEP_CP1_FALL: begin
            pulse_d[P_CP1F] = 1'b1;
            cp1_d           = 1'b0;
          end
          STEP_CP2_RISE: begin
            pulse_d[P_CP2R] = 1'b1;
            cp2_d           = 1'b1;
          end
          default: begin
            pulse_d[P_CP2F] = 1'b1;
            cp2_d           = 1'b0;
          end
        endcase
      end

      if (pre_q == PRE_LAST) begin
        pre_d  = '0;
        step_d = step_next(step_q);
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    // Stretch counter runs off the registered CP2_NEGEDGE, so a pulse already
    // visible when CE drops is still counted exactly once.
    if (SOFT_RES) begin
      rcnt_d = RCNT_LOAD;
    end else if (pulse_q[P_CP2F] && (rcnt_q != '0)) begin
      rcnt_d = rcnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      pre_q   <= '0;
      step_q  <= STEP_CP1_RISE;
      pulse_q <= '0;
      cp1_q   <= 1'b0;
      cp2_q   <= 1'b0;
      rcnt_q  <= RCNT_LOAD;
    end else begin
      pre_q   <= pre_d;
      step_q  <= step_d;
      pulse_q <= pulse_d;
      cp1_q   <= cp1_d;
      cp2_q   <= cp2_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign CP1_POSEDGE = pulse_q[P_CP1R];
  assign CP1_NEGEDGE = pulse_q[P_CP1F];
  assign CP2_POSEDGE = pulse_q[P_CP2R];
  assign CP2_NEGEDGE = pulse_q[P_CP2F];
  assign CP1         = cp1_q;
  assign CP2         = cp2_q;
  assign PHASE       = step_q;
  assign RESETB      = (rcnt_q == '0);

endmodule

// File: tb/tb_upd7800_clkgen.sv
module tb_upd7800_clkgen;

  localparam int DIV_A = 1;
  localparam int RC_A  = 16;
  localparam int DIV_B = 3;
  localparam int RC_B  = 4;

  logic CLK = 1'b0;
  logic RES = 1'b1;
  logic CE = 1'b1;
  logic SOFT_RES = 1'b0;

  always #5 CLK = ~CLK;

  logic a_p1r, a_p1f, a_p2r, a_p2f, a_cp1, a_cp2, a_rstb;
  logic b_p1r, b_p1f, b_p2r, b_p2f, b_cp1, b_cp2, b_rstb;
  logic [1:0] a_ph, b_ph;

  upd7800_clkgen #(.DIV(DIV_A), .RES_CYCLES(RC_A)) u_a (
    .CLK(CLK), .RES(RES), .CE(CE), .SOFT_RES(SOFT_RES),
    .CP1_POSEDGE(a_p1r), .CP1_NEGEDGE(a_p1f),
    .CP2_POSEDGE(a_p2r), .CP2_NEGEDGE(a_p2f),
    .CP1(a_cp1), .CP2(a_cp2), .PHASE(a_ph), .RESETB(a_rstb)
  );

  upd7800_clkgen #(.DIV(DIV_B), .RES_CYCLES(RC_B)) u_b (
    .CLK(CLK), .RES(RES), .CE(CE), .SOFT_RES(SOFT_RES),
    .CP1_POSEDGE(b_p1r), .CP1_NEGEDGE(b_p1f),
    .CP2_POSEDGE(b_p2r), .CP2_NEGEDGE(b_p2f),
    .CP1(b_cp1), .CP2(b_cp2), .PHASE(b_ph), .RESETB(b_rstb)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: t = enabled edges since reset; step k is issued on the
  // enabled edge where t == k*DIV; n2 = CP2_NEGEDGE pulses since last reload.
  int  t[2], issued[2], n2[2], ep[2];
  bit  mvalid = 1'b0;
  int  cyc = 0;

  function automatic int div_of(input int i);
    return (i == 0) ? DIV_A : DIV_B;
  endfunction

  function automatic int rc_of(input int i);
    return (i == 0) ? RC_A : RC_B;
  endfunction

  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (RES) begin
        t[i] = 0; issued[i] = -1; n2[i] = 0; ep[i] = -1;
      end else begin
        if (SOFT_RES) n2[i] = 0;
        else if (ep[i] == 3) n2[i] = n2[i] + 1;
        if (CE && (t[i] % div_of(i) == 0)) begin
          ep[i] = (t[i] / div_of(i)) % 4;
          issued[i] = t[i] / div_of(i);
        end else begin
          ep[i] = -1;
        end
        if (CE) t[i] = t[i] + 1;
      end
    end
    if (RES) mvalid = 1'b1;
    cyc = cyc + 1;
  end

  task automatic cmp(input int i, input logic [3:0] p, input logic [1:0] ph,
                     input logic c1, input logic c2, input logic rb);
    int exp_p;
    exp_p = (ep[i] < 0) ? 0 : (1 << ep[i]);
    chk($sformatf("m%0d_pulses", i), int'(p), exp_p);
    chk($sformatf("m%0d_phase", i), int'(ph), (t[i] / div_of(i)) % 4);
    chk($sformatf("m%0d_cp1", i), int'(c1), (issued[i] >= 0 && issued[i] % 4 == 0) ? 1 : 0);
    chk($sformatf("m%0d_cp2", i), int'(c2), (issued[i] >= 0 && issued[i] % 4 == 2) ? 1 : 0);
    chk($sformatf("m%0d_resetb", i), int'(rb), (n2[i] >= rc_of(i)) ? 1 : 0);
  endtask

  always @(negedge CLK) begin
    if (mvalid) begin
      cmp(0, {a_p2f, a_p2r, a_p1f, a_p1r}, a_ph, a_cp1, a_cp2, a_rstb);
      cmp(1, {b_p2f, b_p2r, b_p1f, b_p1r}, b_ph, b_cp1, b_cp2, b_rstb);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int first, n, cnt, last;

  initial begin
    // Reset for 10 CLK
    repeat (10) @(negedge CLK);
    chk("rst_a_pulses", int'({a_p2f, a_p2r, a_p1f, a_p1r}), 0);
    chk("rst_a_phase", int'(a_ph), 0);
    chk("rst_a_levels", int'({a_cp1, a_cp2}), 0);
    chk("rst_a_resetb", int'(a_rstb), 0);
    chk("rst_b_resetb", int'(b_rstb), 0);

    // Release: first pulse and 64-cycle stretch
    RES = 1'b0;
    @(negedge CLK);
    first = cyc;
    chk("a_first_p1r", int'(a_p1r), 1);
    chk("a_first_cp1", int'(a_cp1), 1);
    chk("a_first_phase", int'(a_ph), 1);
    chk("b_first_p1r", int'(b_p1r), 1);
    chk("b_first_phase", int'(b_ph), 0);
    repeat (3) @(negedge CLK);
    chk("a_p2f_at4", int'(a_p2f), 1);
    chk("b_p1f_at4", int'(b_p1f), 1);
    chk("b_phase_at4", int'(b_ph), 1);
    n = 0;
    while (!a_rstb && n < 500) begin @(negedge CLK); n++; end
    chk("a_resetb_rise", cyc - first, 64);
    chk("a_rise_p1r", int'(a_p1r), 1);

    // CE freeze for 5 CLK right after CP1_NEGEDGE
    RES = 1'b1;
    repeat (2) @(negedge CLK);
    RES = 1'b0;
    @(negedge CLK);
    first = cyc;
    @(negedge CLK);
    chk("frz_p1f", int'(a_p1f), 1);
    CE = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("frz_nopulse", int'({a_p2f, a_p2r, a_p1f, a_p1r}), 0);
    end
    CE = 1'b1;
    @(negedge CLK);
    chk("frz_resume_p2r", int'(a_p2r), 1);
    n = 0;
    while (!a_rstb && n < 500) begin @(negedge CLK); n++; end
    chk("frz_resetb_rise", cyc - first, 69);

    // SOFT_RES for 3 CLK while RESETB=1
    repeat (3) @(negedge CLK);
    SOFT_RES = 1'b1;
    @(negedge CLK);
    chk("soft_a_resetb", int'(a_rstb), 0);
    chk("soft_b_resetb", int'(b_rstb), 0);
    repeat (2) @(negedge CLK);
    SOFT_RES = 1'b0;
    cnt = a_p2f ? 1 : 0;
    last = a_p2f ? 1 : 0;
    n = 0;
    while (n < 500) begin
      @(negedge CLK);
      n++;
      if (a_rstb) break;
      last = a_p2f ? 1 : 0;
      if (a_p2f) cnt++;
    end
    chk("soft_rise_seen", int'(a_rstb), 1);
    chk("soft_p2f_count", cnt, 16);
    chk("soft_rise_after_p2f", last, 1);

    // RES together with SOFT_RES while CP2_POSEDGE visible
    n = 0;
    while (!a_p2r && n < 10) begin @(negedge CLK); n++; end
    chk("mid_p2r_seen", int'(a_p2r), 1);
    RES = 1'b1;
    SOFT_RES = 1'b1;
    @(negedge CLK);
    chk("mid_a_pulses", int'({a_p2f, a_p2r, a_p1f, a_p1r}), 0);
    chk("mid_a_levels", int'({a_cp1, a_cp2}), 0);
    chk("mid_a_phase", int'(a_ph), 0);
    chk("mid_a_resetb", int'(a_rstb), 0);
    chk("mid_b_pulses", int'({b_p2f, b_p2r, b_p1f, b_p1r}), 0);
    RES = 1'b0;
    SOFT_RES = 1'b0;
    @(negedge CLK);
    chk("restart_a_p1r", int'(a_p1r), 1);
    chk("restart_b_p1r", int'(b_p1r), 1);
    repeat (30) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
